// File: rtl/id_ex_pipe_reg.sv
// -----------------------------------------------------------------------------
// id_ex_pipe_reg
//   ID/EX pipeline register with load-use hazard detection and bubble
//   insertion. It captures decoded operands, register addresses and control
//   from decode and drives the EX stage. It is the only source of the
//   decode-side stall for load-use hazards.
//
//   Per-edge priority: flush (bubble) > ex_stall (hold) > hazard (bubble)
//   > normal load of the id_* fields.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   id_valid                    decode slot holds a real instruction
//   id_rsrc_addr/id_rdst_addr   source/destination register addresses
//   id_uses_rsrc/id_uses_rdst   instruction reads Rsrc / Rdst as operands
//   id_rsrc_data/id_rdst_data   register-file read data
//   id_imm, id_ctrl             immediate, opaque EX/MEM/WB control bundle
//   id_reg_write, id_mem_read   writes Rdst / is a load
//   flush                       branch taken; kill the decode instruction
//   ex_stall                    downstream multi-cycle stall; hold EX
//   id_stall                    hold PC and IF/ID this cycle (combinational)
//   ex_*                        registered EX-stage copies of the fields
//   bubble_cnt, flush_cnt       saturating statistics (HAZARD_STATS_EN only)
//
// Optional feature macro: HAZARD_STATS_EN
// -----------------------------------------------------------------------------
module id_ex_pipe_reg #(
    parameter int REG_ADDR_W = 3,
    parameter int DATA_W     = 16,
    parameter int CTRL_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rsrc_addr,
    input  logic [REG_ADDR_W-1:0] id_rdst_addr,
    input  logic                  id_uses_rsrc,
    input  logic                  id_uses_rdst,
    input  logic [DATA_W-1:0]     id_rsrc_data,
    input  logic [DATA_W-1:0]     id_rdst_data,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic [CTRL_W-1:0]     id_ctrl,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    input  logic                  ex_stall,
    output logic                  id_stall,
    output logic                  ex_valid,
    output logic [REG_ADDR_W-1:0] ex_rsrc_addr,
    output logic [REG_ADDR_W-1:0] ex_rdst_addr,
    output logic [DATA_W-1:0]     ex_rsrc_data,
    output logic [DATA_W-1:0]     ex_rdst_data,
    output logic [DATA_W-1:0]     ex_imm,
    output logic [CTRL_W-1:0]     ex_ctrl,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]           bubble_cnt,
    output logic [15:0]           flush_cnt
`endif
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic                  valid_q,     valid_d;
    logic [REG_ADDR_W-1:0] rsrc_addr_q, rsrc_addr_d;
    logic [REG_ADDR_W-1:0] rdst_addr_q, rdst_addr_d;
    logic [DATA_W-1:0]     rsrc_data_q, rsrc_data_d;
    logic [DATA_W-1:0]     rdst_data_q, rdst_data_d;
    logic [DATA_W-1:0]     imm_q,       imm_d;
    logic [CTRL_W-1:0]     ctrl_q,      ctrl_d;
    logic                  reg_write_q, reg_write_d;
    logic                  mem_read_q,  mem_read_d;

    logic hazard_s;
    logic insert_bubble_s;

    // Load-use detection against the instruction currently in EX. In BUBBLE
    // the hazard is masked so one load can never produce two bubbles.
    always_comb begin
        hazard_s = 1'b0;
        if (state_q == ST_BUBBLE) begin
            hazard_s = 1'b0;
        end else begin
            hazard_s = id_valid & valid_q & mem_read_q & reg_write_q &
                       ((id_uses_rsrc & (id_rsrc_addr == rdst_addr_q)) |
                        (id_uses_rdst & (id_rdst_addr == rdst_addr_q)));
        end
    end

    assign insert_bubble_s = hazard_s & ~flush & ~ex_stall;
    assign id_stall        = rst_n & ~flush & (ex_stall | hazard_s);

    // Next EX contents. Bubbles still carry the id_* addresses and data so
    // the forwarding compare sees stable values; only valid/write/load/ctrl
    // are cleared.
    always_comb begin
        valid_d     = valid_q;
        rsrc_addr_d = rsrc_addr_q;
        rdst_addr_d = rdst_addr_q;
        rsrc_data_d = rsrc_data_q;
        rdst_data_d = rdst_data_q;
        imm_d       = imm_q;
        ctrl_d      = ctrl_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        if (ex_stall & ~flush) begin
            valid_d = valid_q;
        end else begin
            rsrc_addr_d = id_rsrc_addr;
            rdst_addr_d = id_rdst_addr;
            rsrc_data_d = id_rsrc_data;
            rdst_data_d = id_rdst_data;
            imm_d       = id_imm;
            if (flush | hazard_s) begin
                valid_d     = 1'b0;
                ctrl_d      = {CTRL_W{1'b0}};
                reg_write_d = 1'b0;
                mem_read_d  = 1'b0;
            end else begin
                valid_d     = id_valid;
                ctrl_d      = id_ctrl;
                reg_write_d = id_reg_write;
                mem_read_d  = id_mem_read;
            end
        end
    end

    // Bubble-tracking FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (insert_bubble_s) begin
                    state_d = ST_BUBBLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_BUBBLE: begin
                if (flush) begin
                    state_d = ST_RUN;
                end else if (ex_stall) begin
                    state_d = ST_BUBBLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // EX-stage register bank and FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            valid_q     <= 1'b0;
            rsrc_addr_q <= {REG_ADDR_W{1'b0}};
            rdst_addr_q <= {REG_ADDR_W{1'b0}};
            rsrc_data_q <= {DATA_W{1'b0}};
            rdst_data_q <= {DATA_W{1'b0}};
            imm_q       <= {DATA_W{1'b0}};
            ctrl_q      <= {CTRL_W{1'b0}};
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            rsrc_addr_q <= rsrc_addr_d;
            rdst_addr_q <= rdst_addr_d;
            rsrc_data_q <= rsrc_data_d;
            rdst_data_q <= rdst_data_d;
            imm_q       <= imm_d;
            ctrl_q      <= ctrl_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_rsrc_addr = rsrc_addr_q;
    assign ex_rdst_addr = rdst_addr_q;
    assign ex_rsrc_data = rsrc_data_q;
    assign ex_rdst_data = rdst_data_q;
    assign ex_imm       = imm_q;
    assign ex_ctrl      = ctrl_q;
    assign ex_reg_write = reg_write_q;
    assign ex_mem_read  = mem_read_q;

`ifdef HAZARD_STATS_EN
    logic [15:0] bubble_cnt_q, bubble_cnt_d;
    logic [15:0] flush_cnt_q,  flush_cnt_d;

    // Saturating statistics counters.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (insert_bubble_s && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end else begin
            bubble_cnt_d = bubble_cnt_q;
        end
        if (flush && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= 16'd0;
            flush_cnt_q  <= 16'd0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [2:0]  id_rsrc_addr, id_rdst_addr;
    logic        id_uses_rsrc, id_uses_rdst;
    logic [15:0] id_rsrc_data, id_rdst_data, id_imm;
    logic [7:0]  id_ctrl;
    logic        id_reg_write, id_mem_read, flush, ex_stall;
    logic        id_stall, ex_valid;
    logic [2:0]  ex_rsrc_addr, ex_rdst_addr;
    logic [15:0] ex_rsrc_data, ex_rdst_data, ex_imm;
    logic [7:0]  ex_ctrl;
    logic        ex_reg_write, ex_mem_read;
`ifdef HAZARD_STATS_EN
    logic [15:0] bubble_cnt, flush_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    id_ex_pipe_reg dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rsrc_addr(id_rsrc_addr), .id_rdst_addr(id_rdst_addr),
        .id_uses_rsrc(id_uses_rsrc), .id_uses_rdst(id_uses_rdst),
        .id_rsrc_data(id_rsrc_data), .id_rdst_data(id_rdst_data),
        .id_imm(id_imm), .id_ctrl(id_ctrl), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .flush(flush), .ex_stall(ex_stall),
        .id_stall(id_stall), .ex_valid(ex_valid),
        .ex_rsrc_addr(ex_rsrc_addr), .ex_rdst_addr(ex_rdst_addr),
        .ex_rsrc_data(ex_rsrc_data), .ex_rdst_data(ex_rdst_data),
        .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read)
`ifdef HAZARD_STATS_EN
        , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: the instruction that should sit in EX, as a record.
    typedef struct packed {
        logic        v;
        logic [2:0]  rs, rd;
        logic [15:0] rsd, rdd, imm;
        logic [7:0]  ctrl;
        logic        rw, mr;
    } ex_t;
    ex_t m;
    int  m_bcnt, m_fcnt;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A load sitting in EX whose destination the decode instruction reads.
    function automatic logic model_hazard();
        logic hit;
        hit = (id_uses_rsrc && id_rsrc_addr == m.rd) || (id_uses_rdst && id_rdst_addr == m.rd);
        return id_valid && m.v && m.mr && m.rw && hit;
    endfunction

    function automatic logic model_stall();
        if (!rst_n || flush) return 1'b0;
        return ex_stall || model_hazard();
    endfunction

    function automatic ex_t bubble_of_id();
        ex_t b;
        b = '{v: 1'b0, rs: id_rsrc_addr, rd: id_rdst_addr, rsd: id_rsrc_data,
              rdd: id_rdst_data, imm: id_imm, ctrl: 8'h00, rw: 1'b0, mr: 1'b0};
        return b;
    endfunction

    task automatic model_edge();
        logic hz;
        hz = model_hazard();
        if (flush) begin
            m = bubble_of_id();
            if (m_fcnt < 65535) m_fcnt++;
        end else if (ex_stall) begin
            m = m;
        end else if (hz) begin
            m = bubble_of_id();
            if (m_bcnt < 65535) m_bcnt++;
        end else begin
            m = '{v: id_valid, rs: id_rsrc_addr, rd: id_rdst_addr, rsd: id_rsrc_data,
                  rdd: id_rdst_data, imm: id_imm, ctrl: id_ctrl, rw: id_reg_write,
                  mr: id_mem_read};
        end
    endtask

    task automatic check_ex();
        check("ex_valid", {31'd0, ex_valid}, {31'd0, m.v});
        check("ex_rsrc_addr", {29'd0, ex_rsrc_addr}, {29'd0, m.rs});
        check("ex_rdst_addr", {29'd0, ex_rdst_addr}, {29'd0, m.rd});
        check("ex_rsrc_data", {16'd0, ex_rsrc_data}, {16'd0, m.rsd});
        check("ex_rdst_data", {16'd0, ex_rdst_data}, {16'd0, m.rdd});
        check("ex_imm", {16'd0, ex_imm}, {16'd0, m.imm});
        check("ex_ctrl", {24'd0, ex_ctrl}, {24'd0, m.ctrl});
        check("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, m.rw});
        check("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, m.mr});
`ifdef HAZARD_STATS_EN
        check("bubble_cnt", {16'd0, bubble_cnt}, m_bcnt);
        check("flush_cnt", {16'd0, flush_cnt}, m_fcnt);
`endif
    endtask

    // One clock: called just after a negedge with inputs already driven.
    task automatic cycle();
        #1;
        check("id_stall", {31'd0, id_stall}, {31'd0, model_stall()});
        @(posedge clk);
        model_edge();
        #1;
        check_ex();
        @(negedge clk);
    endtask

    task automatic drive(logic v, logic [2:0] rs, logic [2:0] rd, logic urs, logic urd,
                         logic rw, logic mr, logic fl, logic st);
        id_valid = v; id_rsrc_addr = rs; id_rdst_addr = rd;
        id_uses_rsrc = urs; id_uses_rdst = urd; id_reg_write = rw; id_mem_read = mr;
        flush = fl; ex_stall = st;
        id_rsrc_data = 16'($urandom); id_rdst_data = 16'($urandom);
        id_imm = 16'($urandom); id_ctrl = 8'($urandom_range(1, 255));
    endtask

    task automatic mid_cycle_reset();
        #2;
        rst_n = 1'b0;
        #1;
        m = '0;
        m_bcnt = 0;
        m_fcnt = 0;
        check_ex();
        check("id_stall_in_reset", {31'd0, id_stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        m = '0; m_bcnt = 0; m_fcnt = 0;
        drive(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        #12;
        check_ex();
        check("id_stall_reset", {31'd0, id_stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First instruction after release appears after one edge.
        drive(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        check("first_valid", {31'd0, ex_valid}, 32'd1);

        // Load R3, then ADD reading R3: one bubble, then the ADD.
        drive(1'b1, 3'd0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        check("load_in_ex", {30'd0, ex_mem_read, ex_reg_write}, 32'd3);
        drive(1'b1, 3'd3, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 check("lu_stall", {31'd0, id_stall}, 32'd1);
        cycle();
        check("lu_bubble", {31'd0, ex_valid}, 32'd0);
        #1 check("lu_stall_once", {31'd0, id_stall}, 32'd0);
        cycle();
        check("lu_add_issued", {28'd0, ex_valid, ex_rsrc_addr}, 32'hB);
`ifdef HAZARD_STATS_EN
        check("lu_bubble_cnt", {16'd0, bubble_cnt}, 32'd1);
`endif

        // No hazard: load R3 then ADD R2,R4; non-load writer then reader.
        drive(1'b1, 3'd0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 3'd2, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 check("nohaz_addr", {31'd0, id_stall}, 32'd0);
        cycle();
        drive(1'b1, 3'd0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 3'd3, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 check("nohaz_alu", {31'd0, id_stall}, 32'd0);
        cycle();
        check("nohaz_issued", {31'd0, ex_valid}, 32'd1);

        // Flush with a load-use hazard pending: flush wins.
        drive(1'b1, 3'd0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 3'd3, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        #1 check("flush_stall", {31'd0, id_stall}, 32'd0);
        cycle();
        check("flush_bubble", {31'd0, ex_valid}, 32'd0);
`ifdef HAZARD_STATS_EN
        check("flush_cnt1", {16'd0, flush_cnt}, 32'd1);
        check("flush_bcnt", {16'd0, bubble_cnt}, 32'd1);
`endif

        // Downstream stall holding load R5 while decode holds a reader of R5.
        drive(1'b1, 3'd0, 3'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'd5, 3'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
            #1 check("dstall_stall", {31'd0, id_stall}, 32'd1);
            cycle();
            check("dstall_hold", {26'd0, ex_valid, ex_mem_read, 1'b0, ex_rdst_addr}, 32'h35);
        end
        drive(1'b1, 3'd5, 3'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 check("dstall_haz", {31'd0, id_stall}, 32'd1);
        cycle();
        check("dstall_bubble", {31'd0, ex_valid}, 32'd0);
        cycle();
        check("dstall_issue", {28'd0, ex_valid, ex_rsrc_addr}, 32'hD);

        // Reset mid-bubble: EX empty, restart in RUN.
        drive(1'b1, 3'd0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 3'd2, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        mid_cycle_reset();
        drive(1'b1, 3'd2, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        check("post_reset_issue", {31'd0, ex_valid}, 32'd1);

        // Randomized traffic against the model; small address space so
        // load-use matches are frequent.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 9) != 0), 3'($urandom), 3'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 11) == 0), ($urandom_range(0, 6) == 0));
            if ($urandom_range(0, 299) == 0) begin
                mid_cycle_reset();
            end else begin
                cycle();
            end
        end

`ifdef HAZARD_STATS_EN
        // Counter saturation: 65537 flushes, then a few more.
        for (int i = 0; i < 65540; i++) begin
            drive(1'b1, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            cycle();
        end
        check("flush_sat", {16'd0, flush_cnt}, 32'h0000FFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register with load-use hazard detection, bubble insertion, stall and flush handling.
- Captures decoded operands, register addresses and control from decode.
- Drives the EX stage, including the current source and destination addresses that the forwarding unit compares against the EX/MEM and MEM/WB write addresses.
- Sole generator of the decode-side stall for load-use hazards.

Parameters:
- REG_ADDR_W, 3, register-file address width.
- DATA_W, 16, operand and immediate width.
- CTRL_W, 8, opaque EX/MEM/WB control bundle width, passed through unchanged.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_rsrc_addr  in  REG_ADDR_W  source register address.
- id_rdst_addr  in  REG_ADDR_W  destination register address.
- id_uses_rsrc  in  1  instruction reads Rsrc.
- id_uses_rdst  in  1  instruction reads Rdst as an operand.
- id_rsrc_data  in  DATA_W  register-file read data for Rsrc.
- id_rdst_data  in  DATA_W  register-file read data for Rdst.
- id_imm  in  DATA_W  sign-extended immediate.
- id_ctrl  in  CTRL_W  control bundle.
- id_reg_write  in  1  instruction writes Rdst.
- id_mem_read  in  1  instruction is a load.
- flush  in  1  branch taken; kill decode instruction.
- ex_stall  in  1  downstream multi-cycle stall; hold EX.
- id_stall  out  1  hold PC and IF/ID this cycle (combinational).
- ex_valid  out  1  EX slot valid.
- ex_rsrc_addr  out  REG_ADDR_W  registered Rsrc address.
- ex_rdst_addr  out  REG_ADDR_W  registered Rdst address.
- ex_rsrc_data  out  DATA_W  registered Rsrc data.
- ex_rdst_data  out  DATA_W  registered Rdst data.
- ex_imm  out  DATA_W  registered immediate.
- ex_ctrl  out  CTRL_W  registered control.
- ex_reg_write  out  1  registered write enable.
- ex_mem_read  out  1  registered load flag.
- bubble_cnt  out  16  present only with the optional feature.
- flush_cnt  out  16  present only with the optional feature.

Behaviour:
- Reset (rst_n=0, async): all ex_* outputs are 0, and the FSM returns to RUN. id_stall is 0 while in reset.
- Latency: 1 cycle from the id_* inputs to the ex_* outputs.
- hazard = id_valid & ex_valid & ex_mem_read & ex_reg_write & ((id_uses_rsrc & id_rsrc_addr==ex_rdst_addr) | (id_uses_rdst & id_rdst_addr==ex_rdst_addr)). This is an exact address compare; there is no special register-0 case.
- Per-edge priority:
  - flush: EX loads a bubble; hazard is ignored.
  - ex_stall: EX holds all fields.
  - hazard: EX loads a bubble; the decode instruction is held upstream.
  - otherwise: EX loads the id_* fields, with ex_valid=id_valid.
- Bubble definition: ex_valid=0, ex_reg_write=0, ex_mem_read=0, ex_ctrl=0. Address and data fields take the current id_* values, so the forwarding compare sees stable values. Writes are suppressed by ex_reg_write=0.
- id_stall = rst_n & ~flush & (ex_stall | hazard).
- FSM states:
  - RUN: default state. hazard & ~flush & ~ex_stall -> BUBBLE.
  - BUBBLE: exactly one cycle after a bubble insertion. hazard is forced to 0 in this state, so a second bubble is impossible. Next edge -> RUN, unless ex_stall, which holds the FSM in BUBBLE. flush in BUBBLE -> RUN.
- Invariant: one bubble per load-use pair, never two.
- Simultaneous flush and ex_stall: flush wins; EX is bubbled and id_stall=0.
- ex_stall together with hazard: hold EX (the load stays in EX), id_stall=1. The hazard is re-evaluated after the stall drops.
- Reset deasserting mid-bubble: the FSM restarts in RUN with EX empty.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined:
  - bubble_cnt increments on each hazard bubble insertion.
  - flush_cnt increments on each edge where flush=1.
  - Both counters saturate at 16'hFFFF and reset to 0.
- When undefined: the counter ports and their logic are absent, and the rest of the behaviour is identical.

Test Plan:
- Reset:
  - Stimulus: assert rst_n=0 mid-cycle with ex_valid=1.
  - Response: all ex_* outputs are 0 immediately (asynchronous); id_stall=0; first valid instruction appears 1 cycle after release.
- Load-use hazard:
  - Stimulus: load R3 (id_mem_read=1, id_reg_write=1, rdst=3), then ADD with rsrc=3.
  - Response: id_stall=1 for exactly 1 cycle; EX shows load, bubble (ex_valid=0), ADD; bubble_cnt=1.
- No hazard:
  - Stimulus: load R3, then ADD with rsrc=2, rdst=4; also a non-load writer of R3 followed by a reader of R3.
  - Response: id_stall stays 0; no bubble is inserted.
- Flush versus hazard:
  - Stimulus: load-use hazard present with flush=1 on the same edge.
  - Response: EX gets a bubble; id_stall=0; FSM stays in RUN; flush_cnt=1; bubble_cnt unchanged.
- Downstream stall:
  - Stimulus: ex_stall=1 for 3 cycles holding load R5 while decode holds a reader of R5.
  - Response: EX is unchanged for 3 cycles; id_stall=1 throughout; then one bubble; then the reader issues.
- Counter saturation (HAZARD_STATS_EN):
  - Stimulus: force 65537 flushes.
  - Response: flush_cnt=16'hFFFF and holds.
